// File: rtl/axi_lite_s_if.sv
// AXI-Lite style bus bundle for axi_lite_s: AR/R/AW/W/B channels.
// 64-bit data, 32-bit address, one strobe bit per 16-bit halfword.
interface axi_lite_s_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_s.sv
// axi_lite_s: AXI-Lite slave in front of a 2^DEPTH_LOG2 x 64-bit memory.
// Independent read (R_IDLE/R_DATA) and write (W_IDLE/W_RESP) FSMs.
// Write strobes are per halfword: wstrb[i] covers bits [16i+15:16i].
// Optional: define AXI_LITE_S_DECERR_EN to answer DECERR (2'b11) outside
// [ADDR_BASE, ADDR_BASE + 8*2^DEPTH_LOG2); otherwise addresses alias by
// index bits and every response is OKAY.
module axi_lite_s #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    axi_lite_s_if.slave s
);
    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;
    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;

    logic [63:0] mem [DEPTH];

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
        return a[DEPTH_LOG2+2:3];
    endfunction

    // Address decode: in-window check only exists when DECERR is enabled.
    logic ar_ok;
    logic aw_in_ok;
`ifdef AXI_LITE_S_DECERR_EN
    function automatic logic in_window(input logic [31:0] a);
        logic [32:0] off;
        // 33-bit subtract: an address below the base borrows into bit 32,
        // so a single "upper bits zero" test covers both ends of the window.
        off = {1'b0, a} - {1'b0, ADDR_BASE};
        return (off >> (DEPTH_LOG2 + 3)) == 33'd0;
    endfunction
    assign ar_ok    = in_window(s.araddr);
    assign aw_in_ok = in_window(s.awaddr);
`else
    assign ar_ok    = 1'b1;
    assign aw_in_ok = 1'b1;
`endif

    // ---------------- read path ----------------
    r_state_e    r_state_q, r_state_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    // Read FSM next state: capture the word on the AR handshake, hold until R handshake.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s.arvalid) begin
                    r_state_d = R_DATA;
                    if (ar_ok) begin
                        rdata_d = mem[word_idx(s.araddr)];
                        rresp_d = OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = DECERR;
                    end
                end
            end
            R_DATA: begin
                if (s.rready) r_state_d = R_IDLE;
            end
        endcase
    end

    // Read FSM state and registered read outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s.arready = (r_state_q == R_IDLE);
    assign s.rvalid  = (r_state_q == R_DATA);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

    // ---------------- write path ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q, w_got_d;
    logic [DEPTH_LOG2-1:0] aw_idx_q, aw_idx_d;
    logic                  aw_ok_q, aw_ok_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  awready, wready, aw_hs, w_hs, commit, mem_we;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  cur_ok;
    logic [63:0]           cur_wdata;
    logic [3:0]            cur_wstrb;

    assign awready = (w_state_q == W_IDLE) && !aw_got_q;
    assign wready  = (w_state_q == W_IDLE) && !w_got_q;
    assign aw_hs   = s.awvalid && awready;
    assign w_hs    = s.wvalid && wready;

    // Either half may already be latched or be handshaking right now.
    assign cur_idx   = aw_got_q ? aw_idx_q : word_idx(s.awaddr);
    assign cur_ok    = aw_got_q ? aw_ok_q  : aw_in_ok;
    assign cur_wdata = w_got_q  ? wdata_q  : s.wdata;
    assign cur_wstrb = w_got_q  ? wstrb_q  : s.wstrb;
    assign commit    = (w_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
    assign mem_we    = commit && cur_ok;

    // Write FSM next state: latch AW/W in any order, commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_idx_d  = aw_idx_q;
        aw_ok_d   = aw_ok_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (commit) begin
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    bresp_d   = cur_ok ? OKAY : DECERR;
                end else begin
                    if (aw_hs) begin
                        aw_got_d = 1'b1;
                        aw_idx_d = word_idx(s.awaddr);
                        aw_ok_d  = aw_in_ok;
                    end
                    if (w_hs) begin
                        w_got_d = 1'b1;
                        wdata_d = s.wdata;
                        wstrb_d = s.wstrb;
                    end
                end
            end
            W_RESP: begin
                if (s.bready) w_state_d = W_IDLE;
            end
        endcase
    end

    // Write FSM state, latched AW/W halves and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_idx_q  <= aw_idx_d;
            aw_ok_q   <= aw_ok_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    assign s.awready = awready;
    assign s.wready  = wready;
    assign s.bvalid  = (w_state_q == W_RESP);
    assign s.bresp   = bresp_q;

    // Memory write port, halfword-granular; contents survive reset, but a
    // commit is never taken while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) mem[cur_idx][16*i +: 16] <= cur_wdata[16*i +: 16];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_s.sv
// Scoreboard bench for axi_lite_s: stimulus pushes expected R/B responses,
// a forked monitor pops and compares on every R and B handshake.
module tb_axi_lite_s;
    localparam int TMO = 50;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rexp_t      r_q[$];
    logic [1:0] b_q[$];

    axi_lite_s_if bus ();

    axi_lite_s #(.ADDR_BASE(32'h8000_0000), .DEPTH_LOG2(8)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout after %0d cycles", nm, TMO);
    endtask

    task automatic push_r(input logic [63:0] d, input logic [1:0] r);
        rexp_t e;
        e.d = d;
        e.r = r;
        r_q.push_back(e);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                            input logic [3:0] st, input logic [1:0] er);
        bit aw_ok, w_ok;
        int n;
        b_q.push_back(er);
        @(posedge clk); #1;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0;
        while (bus.awvalid || bus.wvalid) begin
            @(negedge clk);
            aw_ok = bus.awvalid && bus.awready;
            w_ok  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_ok) bus.awvalid = 1'b0;
            if (w_ok)  bus.wvalid  = 1'b0;
            n++;
            if (n > TMO) begin
                tmo("write_handshake");
                bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            end
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [63:0] d, input logic [1:0] r);
        bit hs;
        int n;
        push_r(d, r);
        @(posedge clk); #1;
        bus.araddr = a; bus.arvalid = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs) begin
            @(negedge clk);
            hs = bus.arready;
            @(posedge clk); #1;
            n++;
            if (!hs && n > TMO) begin
                tmo("read_handshake");
                hs = 1'b1;
            end
        end
        bus.arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.rvalid || bus.bvalid) && n < TMO);
        if (bus.rvalid || bus.bvalid) tmo("drain");
    endtask

    initial begin
        int n;
        rexp_t e;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;

        // Monitor: compare every R/B handshake against the scoreboard queues.
        fork
            forever begin
                @(negedge clk);
                if (rst && bus.rvalid && bus.rready) begin
                    if (r_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: got rdata %h with no expected read", bus.rdata);
                    end else begin
                        e = r_q.pop_front();
                        chk("rdata", bus.rdata, e.d);
                        chk("rresp", {62'd0, bus.rresp}, {62'd0, e.r});
                    end
                end
                if (rst && bus.bvalid && bus.bready) begin
                    if (b_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected: got bresp %b with no expected write", bus.bresp);
                    end else begin
                        chk("bresp", {62'd0, bus.bresp}, {62'd0, b_q.pop_front()});
                    end
                end
            end
        join_none

        // Reset state, during and after reset.
        #3;
        chk("rst_arready", bus.arready, 1);
        chk("rst_awready", bus.awready, 1);
        chk("rst_wready",  bus.wready, 1);
        chk("rst_rvalid",  bus.rvalid, 0);
        chk("rst_bvalid",  bus.bvalid, 0);
        chk("rst_rdata",   bus.rdata, 0);
        chk("rst_rresp",   {62'd0, bus.rresp}, 0);
        chk("rst_bresp",   {62'd0, bus.bresp}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {61'd0, bus.arready, bus.awready, bus.wready}, 64'd7);

        // Basic write then read back.
        do_write(32'h8000_0010, 64'h1122_3344_5566_7788, 4'hF, 2'b00);
        drain();
        do_read(32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00);
        drain();

        // Halfword strobes over an all-ones word; zero strobe writes nothing.
        do_write(32'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 2'b00);
        drain();
        do_write(32'h8000_0020, 64'h0, 4'b0101, 2'b00);
        drain();
        do_read(32'h8000_0020, 64'hFFFF_0000_FFFF_0000, 2'b00);
        drain();
        do_write(32'h8000_0027, 64'h1234, 4'h0, 2'b00);
        drain();
        do_read(32'h8000_0020, 64'hFFFF_0000_FFFF_0000, 2'b00);
        drain();

        // W three cycles ahead of AW.
        bus.bready = 1'b0;
        @(posedge clk); #1;
        bus.wdata = 64'hCAFE_F00D_DEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        chk("wfirst_wready", bus.wready, 1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wfirst_wready_low", bus.wready, 0);
            chk("wfirst_awready",    bus.awready, 1);
            chk("wfirst_bvalid_low", bus.bvalid, 0);
            @(posedge clk); #1;
        end
        bus.awaddr = 32'h8000_0030; bus.awvalid = 1'b1;
        @(negedge clk);
        chk("aw_hs_bvalid_low", bus.bvalid, 0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        @(negedge clk);
        chk("bvalid_after_aw", bus.bvalid, 1);
        chk("wresp_awready",   bus.awready, 0);
        b_q.push_back(2'b00);
        @(posedge clk); #1;
        bus.bready = 1'b1;
        drain();
        do_read(32'h8000_0030, 64'hCAFE_F00D_DEAD_BEEF, 2'b00);
        drain();

        // Same-cycle AR and write commit to one word: read sees old data.
        do_write(32'h8000_0040, 64'hAAAA_0000_AAAA_0000, 4'hF, 2'b00);
        drain();
        push_r(64'hAAAA_0000_AAAA_0000, 2'b00);
        b_q.push_back(2'b00);
        @(posedge clk); #1;
        bus.araddr = 32'h8000_0040; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0040; bus.wdata = 64'h0123_4567_89AB_CDEF;
        bus.wstrb = 4'hF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        chk("same_cycle_ready", {61'd0, bus.arready, bus.awready, bus.wready}, 64'd7);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        drain();
        do_read(32'h8000_0040, 64'h0123_4567_89AB_CDEF, 2'b00);
        drain();

        // R stall: rready low for 5 cycles.
        bus.rready = 1'b0;
        push_r(64'h1122_3344_5566_7788, 2'b00);
        @(posedge clk); #1;
        bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1;
        @(negedge clk);
        chk("stall_ar_ready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rvalid",  bus.rvalid, 1);
            chk("stall_rdata",   bus.rdata, 64'h1122_3344_5566_7788);
            chk("stall_arready", bus.arready, 0);
            @(posedge clk); #1;
        end
        bus.rready = 1'b1;
        drain();

        // Reset while bvalid is held.
        bus.bready = 1'b0;
        @(posedge clk); #1;
        bus.awaddr = 32'h8000_0060; bus.wdata = 64'h6; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.bvalid && n < TMO);
        chk("pre_rst_bvalid", bus.bvalid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_bvalid",  bus.bvalid, 0);
        chk("mid_rst_awready", bus.awready, 1);
        chk("mid_rst_wready",  bus.wready, 1);
        chk("mid_rst_arready", bus.arready, 1);
        #1 rst = 1'b1;
        bus.bready = 1'b1;

        // A latched but uncommitted W is dropped by reset.
        do_write(32'h8000_0050, 64'h5050_5050_5050_5050, 4'hF, 2'b00);
        drain();
        @(posedge clk); #1;
        bus.wdata = 64'hDEAD_DEAD_DEAD_DEAD; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        @(negedge clk);
        chk("pending_w_wready", bus.wready, 0);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        do_read(32'h8000_0050, 64'h5050_5050_5050_5050, 2'b00);
        drain();

`ifdef AXI_LITE_S_DECERR_EN
        // Out-of-window accesses: DECERR, zero data, memory untouched.
        do_write(32'h8000_0000, 64'h0BAD_0BAD_0000_1111, 4'hF, 2'b00);
        drain();
        do_read(32'h0000_0000, 64'h0, 2'b11);
        drain();
        do_write(32'h0000_0000, 64'hFFFF_EEEE_DDDD_CCCC, 4'hF, 2'b11);
        drain();
        do_read(32'h8000_0800, 64'h0, 2'b11);
        drain();
        do_read(32'h8000_0000, 64'h0BAD_0BAD_0000_1111, 2'b00);
        drain();
`else
        // Without decode, addresses alias by index bits and respond OKAY.
        do_write(32'h0000_0008, 64'h0A11_A500_0A11_A500, 4'hF, 2'b00);
        drain();
        do_read(32'h8000_0008, 64'h0A11_A500_0A11_A500, 2'b00);
        drain();
        do_read(32'h1234_5808, 64'h0A11_A500_0A11_A500, 2'b00);
        drain();
`endif

        repeat (3) @(negedge clk);
        chk("r_queue_empty", r_q.size(), 0);
        chk("b_queue_empty", b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_s.md
AXI_LITE_S -- requirements
Module: axi_lite_s

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of the number of 64-bit memory words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports araddr input 32, arvalid input 1, arready output 1: read-address channel.
REQ-006 SHALL have ports rdata output 64, rresp output 2, rvalid output 1, rready input 1: read-data channel.
REQ-007 SHALL have ports awaddr input 32, awvalid input 1, awready output 1: write-address channel.
REQ-008 SHALL have ports wdata input 64, wstrb input 4, wvalid input 1, wready output 1: write-data channel.
REQ-009 SHALL have ports bresp output 2, bvalid output 1, bready input 1: write-response channel.

Function
REQ-010 SHALL contain a memory of 2^DEPTH_LOG2 words x 64 bits, indexed by addr[DEPTH_LOG2+2:3]; addr[2:0] ignored.
REQ-011 SHALL run a read FSM with states R_IDLE and R_DATA; arready = (state==R_IDLE), rvalid = (state==R_DATA).
REQ-012 SHALL, on arvalid&arready, register the indexed word into rdata and rresp, then move to R_DATA on the next edge.
REQ-013 SHALL hold rdata/rresp/rvalid stable in R_DATA until rvalid&rready, then return to R_IDLE; no back-to-back: one-cycle R_IDLE gap minimum.
REQ-014 SHALL run a write FSM with states W_IDLE and W_RESP, plus flags aw_got and w_got.
REQ-015 SHALL drive awready = (W_IDLE & !aw_got) and wready = (W_IDLE & !w_got); AW and W accepted in any order or the same cycle, each latched into internal registers.
REQ-016 SHALL, in the cycle where both AW and W are held (latched or handshaking that cycle), commit the write and enter W_RESP on the next edge with bvalid=1, clearing both flags.
REQ-017 SHALL apply wstrb per halfword: wstrb[i] enables bytes 2i and 2i+1 of the word; wstrb=0 writes nothing but still responds.
REQ-018 SHALL hold bvalid/bresp until bvalid&bready, then return to W_IDLE.
REQ-019 SHALL give a same-cycle AR handshake and write commit to the same word the pre-write data.
REQ-020 SHALL keep read and write FSMs fully independent; neither stalls the other.
REQ-021 SHALL drive rresp/bresp 2'b00 (OKAY) except as in REQ-026.

Reset
REQ-022 SHALL, while rst=0, force R_IDLE, W_IDLE, aw_got=0, w_got=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, asynchronously.
REQ-023 SHALL therefore show arready=1, awready=1, wready=1 during and after reset.
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation; a pending uncommitted write SHALL not reach memory; memory contents are not reset.

Configuration
REQ-025 SHALL, without AXI_LITE_S_DECERR_EN, alias all addresses onto memory by index bits only, always OKAY.
REQ-026 SHALL, with AXI_LITE_S_DECERR_EN defined, treat addresses outside [ADDR_BASE, ADDR_BASE+8*2^DEPTH_LOG2) as DECERR: rresp/bresp=2'b11, rdata=0, write suppressed; handshake timing unchanged.

Verification
REQ-027 SHALL cover: write awaddr=0x8000_0010, wdata=0x1122334455667788, wstrb=4'hF, then read same -> rdata=0x1122334455667788, rresp=0, bresp=0.
REQ-028 SHALL cover: W presented 3 cycles before AW -> wready drops after W handshake, bvalid rises 1 cycle after AW handshake.
REQ-029 SHALL cover: prior word all-ones, write 0 with wstrb=4'b0101 -> read 0xFFFF0000FFFF0000.
REQ-030 SHALL cover: rready held 0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout.
REQ-031 SHALL cover: rst=0 pulsed while bvalid=1 -> bvalid=0 immediately, awready=wready=arready=1.
REQ-032 SHALL cover, with AXI_LITE_S_DECERR_EN: read 0x0000_0000 -> rresp=2'b11, rdata=0; write there -> bresp=2'b11, memory unchanged.
